// File: rtl/dtack_generator.sv
// DTACK/BERR generator for a 68K-style bus.
// Times internal devices, waits on external acks, times out to BERR.
module dtack_generator #(
  parameter int ROM_WAIT       = 0,
  parameter int RAM_WAIT       = 1,
  parameter int IO_WAIT        = 2,
  parameter int OFFBOARD_WAIT  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic OffBoardMemory_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic DMASelect_L,
  input  logic GraphicsCS_L,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  input  logic DmaDtack_L,
  input  logic GraphicsDtack_L,
  output logic DTACK_L,
  output logic BERR_L,
  output logic MultiSelect_H
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_BERR
  } state_t;

  typedef enum logic [3:0] {
    D_NONE, D_ROM, D_RAM, D_IO, D_DRAM,
    D_CAN, D_DMA, D_GFX, D_OFF
  } dev_t;

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);
  localparam logic [3:0] OFF_W = 4'(OFFBOARD_WAIT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  dev_t       dev_q, dev_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] tmo_q, tmo_d;
  logic       dtack_l_q, dtack_l_d;
  logic       berr_l_q, berr_l_d;
  logic       multi_q, multi_d;

  logic [7:0] sel;
  logic       start;
  logic       multi_now;
  dev_t       dev_sel;
  logic [3:0] sel_wait;
  logic       sel_internal;
  logic       ack_in;

  assign sel = {OffBoardMemory_H, ~GraphicsCS_L, ~DMASelect_L,
                CanBusSelect_H, DramSelect_H, IOSelect_H,
                OnChipRamSelect_H, OnChipRomSelect_H};

  assign start = (state_q == S_IDLE) && !AS_L
                 && (!UDS_L || !LDS_L);

  assign multi_now = (sel & (sel - 8'd1)) != 8'd0;

  // Fixed-priority pick of the device serving this cycle.
  always_comb begin
    dev_sel      = D_NONE;
    sel_wait     = 4'd0;
    sel_internal = 1'b0;
    if (sel[0]) begin
      dev_sel = D_ROM; sel_wait = ROM_W; sel_internal = 1'b1;
    end else if (sel[1]) begin
      dev_sel = D_RAM; sel_wait = RAM_W; sel_internal = 1'b1;
    end else if (sel[2]) begin
      dev_sel = D_IO; sel_wait = IO_W; sel_internal = 1'b1;
    end else if (sel[3]) begin
      dev_sel = D_DRAM;
    end else if (sel[4]) begin
      dev_sel = D_CAN;
    end else if (sel[5]) begin
      dev_sel = D_DMA;
    end else if (sel[6]) begin
      dev_sel = D_GFX;
    end else if (sel[7]) begin
      dev_sel = D_OFF; sel_wait = OFF_W; sel_internal = 1'b1;
    end
  end

  // Acknowledge source for the latched device only.
  always_comb begin
    ack_in = 1'b0;
    case (dev_q)
      D_ROM, D_RAM, D_IO, D_OFF: ack_in = (wait_q == 4'd0);
      D_DRAM:  ack_in = !DramDtack_L;
      D_CAN:   ack_in = !CanBusDtack_L;
      D_DMA:   ack_in = !DmaDtack_L;
      D_GFX:   ack_in = !GraphicsDtack_L;
      default: ack_in = 1'b0;
    endcase
  end

  // Next-state, counters and registered strobe values.
  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    multi_d = multi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dev_d   = dev_sel;
          tmo_d   = 8'd0;
          multi_d = multi_q | multi_now;
          if (sel_internal && sel_wait == 4'd0) begin
            state_d = S_ACK;
            wait_d  = 4'd0;
          end else begin
            state_d = S_WAIT;
            wait_d  = sel_internal ? sel_wait - 4'd1 : 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (AS_L) begin
          state_d = S_IDLE;
        end else if (ack_in) begin
          state_d = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_BERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        end
      end
      S_ACK, S_BERR: begin
        if (AS_L) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    dtack_l_d = (state_d != S_ACK);
    berr_l_d  = (state_d != S_BERR);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q   <= S_IDLE;
      dev_q     <= D_NONE;
      wait_q    <= 4'd0;
      tmo_q     <= 8'd0;
      dtack_l_q <= 1'b1;
      berr_l_q  <= 1'b1;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      dtack_l_q <= dtack_l_d;
      berr_l_q  <= berr_l_d;
      multi_q   <= multi_d;
    end
  end

  assign DTACK_L       = dtack_l_q;
  assign BERR_L        = berr_l_q;
  assign MultiSelect_H = multi_q;

endmodule

// File: tb/tb_dtack_generator.sv
// Scenario bench for dtack_generator.
// Expected response latencies are queued at stimulus time, popped on response.
module tb_dtack_generator;

  logic Clk, Reset_H, AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic OffBoardMemory_H, DramSelect_H, CanBusSelect_H;
  logic DMASelect_L, GraphicsCS_L;
  logic DramDtack_L, CanBusDtack_L, DmaDtack_L, GraphicsDtack_L;
  logic DTACK_L, BERR_L, MultiSelect_H;

  typedef struct {
    bit berr;
    int lat;
  } exp_t;

  exp_t sb[$];
  int tests  = 0;
  int failed = 0;

  dtack_generator #(
    .ROM_WAIT(0), .RAM_WAIT(8), .IO_WAIT(2),
    .OFFBOARD_WAIT(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H),
    .OnChipRamSelect_H(OnChipRamSelect_H),
    .IOSelect_H(IOSelect_H),
    .OffBoardMemory_H(OffBoardMemory_H),
    .DramSelect_H(DramSelect_H),
    .CanBusSelect_H(CanBusSelect_H),
    .DMASelect_L(DMASelect_L),
    .GraphicsCS_L(GraphicsCS_L),
    .DramDtack_L(DramDtack_L),
    .CanBusDtack_L(CanBusDtack_L),
    .DmaDtack_L(DmaDtack_L),
    .GraphicsDtack_L(GraphicsDtack_L),
    .DTACK_L(DTACK_L), .BERR_L(BERR_L),
    .MultiSelect_H(MultiSelect_H)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0;
    IOSelect_H = 1'b0; OffBoardMemory_H = 1'b0;
    DramSelect_H = 1'b0; CanBusSelect_H = 1'b0;
    DMASelect_L = 1'b1; GraphicsCS_L = 1'b1;
    DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
    DmaDtack_L = 1'b1; GraphicsDtack_L = 1'b1;
  endtask

  // bit order: rom ram io dram can dma gfx off
  task automatic drive_sel(input logic [7:0] m);
    OnChipRomSelect_H = m[0];
    OnChipRamSelect_H = m[1];
    IOSelect_H        = m[2];
    DramSelect_H      = m[3];
    CanBusSelect_H    = m[4];
    DMASelect_L       = !m[5];
    GraphicsCS_L      = !m[6];
    OffBoardMemory_H  = m[7];
  endtask

  task automatic set_ack(input int dev);
    case (dev)
      3: DramDtack_L = 1'b0;
      4: CanBusDtack_L = 1'b0;
      5: DmaDtack_L = 1'b0;
      6: GraphicsDtack_L = 1'b0;
      default: ;
    endcase
  endtask

  // Starts a cycle and measures edges from the start edge to the first
  // low strobe (-1 if none within the budget).
  task automatic run_cycle(
    input logic [7:0] m, input int ack_dev, input int ack_after,
    input bit noise, input bit use_lds,
    output int lat, output bit berr, output bit both);
    lat = -1; berr = 1'b0; both = 1'b0;
    drive_sel(m);
    AS_L = 1'b0;
    if (use_lds) LDS_L = 1'b0;
    else UDS_L = 1'b0;
    if (noise) begin
      CanBusDtack_L = 1'b0;
      DmaDtack_L = 1'b0;
      GraphicsDtack_L = 1'b0;
    end
    if (ack_after < 0) set_ack(ack_dev);
    for (int k = 0; k < 40; k++) begin
      tick;
      if (!DTACK_L && !BERR_L) both = 1'b1;
      if (!DTACK_L || !BERR_L) begin
        lat = k;
        berr = !BERR_L;
        break;
      end
      if (k == ack_after) set_ack(ack_dev);
    end
  endtask

  task automatic end_cycle;
    idle_inputs;
    tick;
  endtask

  task automatic test_reset;
    Reset_H = 1'b1;
    idle_inputs;
    tick; tick;
    tests++;
    if (DTACK_L !== 1'b1 || BERR_L !== 1'b1 || MultiSelect_H !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got dtack=%b berr=%b multi=%b, expected 1 1 0",
               DTACK_L, BERR_L, MultiSelect_H);
    end
    Reset_H = 1'b0;
    tick;
  endtask

  task automatic test_rom;
    exp_t e; int lat; bit b, both;
    sb.push_back('{berr: 1'b0, lat: 0});
    run_cycle(8'h01, -1, -1, 1'b0, 1'b0, lat, b, both);
    e = sb.pop_front();
    tests++;
    if (lat !== e.lat || b !== e.berr || both) begin
      failed++;
      $display("FAIL rom_read: got lat=%0d berr=%0b both=%0b, expected lat=%0d berr=%0b",
               lat, b, both, e.lat, e.berr);
    end
    tick;
    tests++;
    if (DTACK_L !== 1'b0) begin
      failed++;
      $display("FAIL rom_hold: got dtack=%b, expected 0", DTACK_L);
    end
    end_cycle;
    tests++;
    if (DTACK_L !== 1'b1 || BERR_L !== 1'b1) begin
      failed++;
      $display("FAIL rom_release: got dtack=%b berr=%b, expected 1 1",
               DTACK_L, BERR_L);
    end
  endtask

  task automatic test_internal_waits;
    logic [7:0] masks[3];
    int lats[3];
    exp_t e; int lat; bit b, both;
    masks[0] = 8'h04; lats[0] = 2;
    masks[1] = 8'h02; lats[1] = 8;
    masks[2] = 8'h80; lats[2] = 4;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{berr: 1'b0, lat: lats[i]});
      run_cycle(masks[i], -1, -1, 1'b0, (i == 2), lat, b, both);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || b !== e.berr || both) begin
        failed++;
        $display("FAIL internal_wait[%0d]: got lat=%0d berr=%0b, expected lat=%0d berr=%0b",
                 i, lat, b, e.lat, e.berr);
      end
      end_cycle;
    end
  endtask

  task automatic test_external;
    logic [7:0] masks[4];
    int devs[4], after[4], lats[4];
    bit noise[4];
    exp_t e; int lat; bit b, both;
    masks[0] = 8'h08; devs[0] = 3; after[0] = 4;  noise[0] = 1; lats[0] = 5;
    masks[1] = 8'h20; devs[1] = 5; after[1] = -1; noise[1] = 0; lats[1] = 1;
    masks[2] = 8'h40; devs[2] = 6; after[2] = 2;  noise[2] = 0; lats[2] = 3;
    masks[3] = 8'h10; devs[3] = 4; after[3] = 0;  noise[3] = 0; lats[3] = 1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{berr: 1'b0, lat: lats[i]});
      run_cycle(masks[i], devs[i], after[i], noise[i], 1'b0, lat, b, both);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || b !== e.berr || both) begin
        failed++;
        $display("FAIL external[%0d]: got lat=%0d berr=%0b, expected lat=%0d berr=%0b",
                 i, lat, b, e.lat, e.berr);
      end
      end_cycle;
    end
  endtask

  task automatic test_timeout;
    exp_t e; int lat; bit b, both;
    sb.push_back('{berr: 1'b1, lat: 16});
    run_cycle(8'h00, -1, -1, 1'b0, 1'b0, lat, b, both);
    e = sb.pop_front();
    tests++;
    if (lat !== e.lat || b !== e.berr || both) begin
      failed++;
      $display("FAIL timeout: got lat=%0d berr=%0b, expected lat=%0d berr=%0b",
               lat, b, e.lat, e.berr);
    end
    tick;
    tests++;
    if (BERR_L !== 1'b0 || DTACK_L !== 1'b1) begin
      failed++;
      $display("FAIL berr_hold: got dtack=%b berr=%b, expected 1 0",
               DTACK_L, BERR_L);
    end
    end_cycle;
    tests++;
    if (DTACK_L !== 1'b1 || BERR_L !== 1'b1) begin
      failed++;
      $display("FAIL berr_release: got dtack=%b berr=%b, expected 1 1",
               DTACK_L, BERR_L);
    end
  endtask

  task automatic test_ack_vs_timeout;
    exp_t e; int lat; bit b, both;
    sb.push_back('{berr: 1'b0, lat: 16});
    run_cycle(8'h08, 3, 15, 1'b0, 1'b0, lat, b, both);
    e = sb.pop_front();
    tests++;
    if (lat !== e.lat || b !== e.berr || both) begin
      failed++;
      $display("FAIL ack_wins: got lat=%0d berr=%0b, expected lat=%0d berr=%0b",
               lat, b, e.lat, e.berr);
    end
    end_cycle;
  endtask

  task automatic test_abort;
    bit seen;
    seen = 1'b0;
    drive_sel(8'h02);
    AS_L = 1'b0; UDS_L = 1'b0;
    tick; tick; tick;
    idle_inputs;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (!DTACK_L || !BERR_L) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL abort: got strobe=%0b, expected 0", seen);
    end
  endtask

  task automatic test_idle_ignore;
    bit seen;
    exp_t e; int lat; bit b, both;
    seen = 1'b0;
    drive_sel(8'h0F);
    DramDtack_L = 1'b0; UDS_L = 1'b0;
    tick; tick;
    UDS_L = 1'b1; AS_L = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (!DTACK_L || !BERR_L) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL idle_ignore: got strobe=%0b, expected 0", seen);
    end
    idle_inputs;
    tick;
    sb.push_back('{berr: 1'b0, lat: 0});
    run_cycle(8'h01, -1, -1, 1'b0, 1'b0, lat, b, both);
    e = sb.pop_front();
    tests++;
    if (lat !== e.lat || b !== e.berr) begin
      failed++;
      $display("FAIL after_idle: got lat=%0d, expected lat=%0d", lat, e.lat);
    end
    end_cycle;
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; bit b, both;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{berr: 1'b0, lat: 0});
      run_cycle(8'h01, -1, -1, 1'b0, 1'b0, lat, b, both);
      e = sb.pop_front();
      tests++;
      if (lat !== e.lat || b !== e.berr) begin
        failed++;
        $display("FAIL back_to_back[%0d]: got lat=%0d, expected lat=%0d",
                 i, lat, e.lat);
      end
      end_cycle;
    end
  endtask

  task automatic test_multi;
    exp_t e; int lat; bit b, both;
    tests++;
    if (MultiSelect_H !== 1'b0) begin
      failed++;
      $display("FAIL multi_pre: got %b, expected 0", MultiSelect_H);
    end
    sb.push_back('{berr: 1'b0, lat: 0});
    run_cycle(8'h05, -1, -1, 1'b0, 1'b0, lat, b, both);
    e = sb.pop_front();
    tests++;
    if (lat !== e.lat || b !== e.berr || MultiSelect_H !== 1'b1) begin
      failed++;
      $display("FAIL multi_rom: got lat=%0d multi=%b, expected lat=%0d multi=1",
               lat, MultiSelect_H, e.lat);
    end
    end_cycle;
    run_cycle(8'h02, -1, -1, 1'b0, 1'b0, lat, b, both);
    end_cycle;
    tests++;
    if (MultiSelect_H !== 1'b1) begin
      failed++;
      $display("FAIL multi_sticky: got %b, expected 1", MultiSelect_H);
    end
  endtask

  task automatic test_reset_in_ack;
    int lat; bit b, both;
    run_cycle(8'h01, -1, -1, 1'b0, 1'b0, lat, b, both);
    tests++;
    if (DTACK_L !== 1'b0) begin
      failed++;
      $display("FAIL ack_before_reset: got dtack=%b, expected 0", DTACK_L);
    end
    #2 Reset_H = 1'b1;
    #1;
    tests++;
    if (DTACK_L !== 1'b1 || BERR_L !== 1'b1 || MultiSelect_H !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: got dtack=%b berr=%b multi=%b, expected 1 1 0",
               DTACK_L, BERR_L, MultiSelect_H);
    end
    idle_inputs;
    Reset_H = 1'b0;
    tick; tick;
    tests++;
    if (DTACK_L !== 1'b1 || BERR_L !== 1'b1) begin
      failed++;
      $display("FAIL post_reset: got dtack=%b berr=%b, expected 1 1",
               DTACK_L, BERR_L);
    end
  endtask

  initial begin
    Reset_H = 1'b1;
    idle_inputs;
    test_reset;
    test_rom;
    test_internal_waits;
    test_external;
    test_timeout;
    test_ack_vs_timeout;
    test_abort;
    test_idle_ignore;
    test_back_to_back;
    test_multi;
    test_reset_in_ack;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
